// File: rtl/digit_pkg.sv
// Constants and FSM status encoding shared by the template scorer and the digit-decision stage.
package digit_pkg;

   localparam int IMG_PIXELS = 2560;
   localparam int PIX_ADDR_W = 12;
   localparam int SCORE_W    = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/template_scorer_if.sv
// Lock-step read port to one template ROM and the binarized image buffer (one-cycle read latency).
// The scorer is the master and drives enables and addresses; the memories return one bit each.
interface template_scorer_if #(
   parameter int ADDR_W = 12
) ();
   logic              rom_ce;
   logic              rom_oce;
   logic [ADDR_W-1:0] rom_ad;
   logic              rom_dout;
   logic              img_re;
   logic [ADDR_W-1:0] img_ad;
   logic              img_dout;

   modport master (
      output rom_ce, rom_oce, rom_ad, img_re, img_ad,
      input  rom_dout, img_dout
   );

   modport slave (
      input  rom_ce, rom_oce, rom_ad, img_re, img_ad,
      output rom_dout, img_dout
   );
endinterface

// File: rtl/score_accum.sv
// Agreement and shared-stroke counters fed one pixel pair per cycle, one cycle behind the read enable.
// No backpressure: a beat is counted in the cycle after its enable; clr wins over counting.
module score_accum #(
   parameter int SCORE_W = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               en,
   input  logic               tpl_bit,
   input  logic               img_bit,
   output logic [SCORE_W-1:0] match_cnt,
   output logic [SCORE_W-1:0] ink_cnt
);
   logic valid_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_d   <= 1'b0;
         match_cnt <= '0;
         ink_cnt   <= '0;
      end else begin
         valid_d <= en;
         if (clr) begin
            match_cnt <= '0;
            ink_cnt   <= '0;
         end else if (valid_d) begin
            if (tpl_bit == img_bit)
               match_cnt <= match_cnt + SCORE_W'(1);
            // 0 is stroke in both sources
            if (!tpl_bit && !img_bit)
               ink_cnt <= ink_cnt + SCORE_W'(1);
         end
      end
   end
endmodule

// File: rtl/template_scorer.sv
// Scans PIXELS template/image bit pairs once per start; done pulses PIXELS+2 cycles after start.
// No backpressure: start is honoured only in IDLE and ignored while a scan is in flight.
module template_scorer
   import digit_pkg::*;
#(
   parameter int PIXELS  = IMG_PIXELS,
   parameter int ADDR_W  = PIX_ADDR_W,
   parameter int SCORE_W = digit_pkg::SCORE_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [SCORE_W-1:0] match_cnt,
   output logic [SCORE_W-1:0] ink_cnt,
   template_scorer_if.master  mem
);
   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr;
   logic              last;
   logic              clr;
   logic              rd_en;

   assign last  = (addr == ADDR_W'(PIXELS - 1));
   assign rd_en = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
               clr       = 1'b1;
            end
         end
         RUN:     if (last) state_nxt = DRAIN;
         DRAIN:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Address holds through DRAIN/DONE and is back at 0 by the time IDLE is re-entered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         addr <= '0;
      else if (state == RUN && !last)
         addr <= addr + ADDR_W'(1);
      else if (state == DONE || state == IDLE)
         addr <= '0;
   end

   assign mem.rom_ce  = rd_en;
   assign mem.rom_oce = rd_en;
   assign mem.img_re  = rd_en;
   assign mem.rom_ad  = addr;
   assign mem.img_ad  = addr;

   assign busy = (state == RUN) || (state == DRAIN);
   assign done = (state == DONE);

   score_accum #(.SCORE_W(SCORE_W)) u_accum (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .en        (rd_en),
      .tpl_bit   (mem.rom_dout),
      .img_bit   (mem.img_dout),
      .match_cnt (match_cnt),
      .ink_cnt   (ink_cnt)
   );
endmodule

// File: tb/tb_template_scorer.sv
// Directed bench: a default-size scorer (2560 pixels) and a 16-pixel scorer, each with its own memory models.
module tb_template_scorer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_b, rst_s, start_b, start_s;
   logic        busy_b, busy_s, done_b, done_s;
   logic [11:0] match_b, ink_b, match_s, ink_s;

   template_scorer_if #(.ADDR_W(12)) mb ();
   template_scorer_if #(.ADDR_W(12)) ms ();

   template_scorer dut_b (
      .clk(clk), .rst_n(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
      .match_cnt(match_b), .ink_cnt(ink_b), .mem(mb)
   );

   template_scorer #(.PIXELS(16)) dut_s (
      .clk(clk), .rst_n(rst_s), .start(start_s), .busy(busy_s), .done(done_s),
      .match_cnt(match_s), .ink_cnt(ink_s), .mem(ms)
   );

   bit tpl_b [4096];
   bit img_b [4096];
   bit tpl_s [4096];
   bit img_s [4096];

   always @(posedge clk) begin
      if (mb.rom_ce) mb.rom_dout <= tpl_b[mb.rom_ad];
      if (mb.img_re) mb.img_dout <= img_b[mb.img_ad];
      if (ms.rom_ce) ms.rom_dout <= tpl_s[ms.rom_ad];
      if (ms.img_re) ms.img_dout <= img_s[ms.img_ad];
   end

   bit          sel_s;
   logic        cur_busy, cur_done, cur_ce, cur_oce, cur_re;
   logic [11:0] cur_ad, cur_img_ad, cur_match, cur_ink;
   assign cur_busy   = sel_s ? busy_s     : busy_b;
   assign cur_done   = sel_s ? done_s     : done_b;
   assign cur_ce     = sel_s ? ms.rom_ce  : mb.rom_ce;
   assign cur_oce    = sel_s ? ms.rom_oce : mb.rom_oce;
   assign cur_re     = sel_s ? ms.img_re  : mb.img_re;
   assign cur_ad     = sel_s ? ms.rom_ad  : mb.rom_ad;
   assign cur_img_ad = sel_s ? ms.img_ad  : mb.img_ad;
   assign cur_match  = sel_s ? match_s    : match_b;
   assign cur_ink    = sel_s ? ink_s      : ink_b;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Starts one scan on the selected DUT and checks latency, address trace, busy window and scores.
   task automatic run_scan(input int pix, input string tag, input int exp_m, input int exp_i);
      int lat, ce_n, busy_n, nxt_ad;
      bit trace_ok;
      @(negedge clk);
      if (sel_s) start_s = 1'b1; else start_b = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      start_b = 1'b0;
      lat = -1; ce_n = 0; busy_n = 0; nxt_ad = 0; trace_ok = 1'b1;
      for (int cyc = 1; cyc <= pix + 40; cyc++) begin
         if (cur_ad !== cur_img_ad) trace_ok = 1'b0;
         if (cur_ce) begin
            if (cur_ad != 12'(nxt_ad) || cyc != nxt_ad + 1 || !cur_oce || !cur_re)
               trace_ok = 1'b0;
            nxt_ad++;
            ce_n++;
         end else if (cur_re || cur_oce) begin
            trace_ok = 1'b0;
         end
         if (cur_busy) busy_n++;
         if (cur_done) begin
            lat = cyc;
            break;
         end
         @(negedge clk);
      end
      chk({tag, " done latency"}, lat, pix + 2);
      chk({tag, " match_cnt"}, int'(cur_match), exp_m);
      chk({tag, " ink_cnt"}, int'(cur_ink), exp_i);
      chk({tag, " busy cycles"}, busy_n, pix + 1);
      chk({tag, " enable cycles"}, ce_n, pix);
      chk({tag, " address trace ok"}, int'(trace_ok), 1);
      @(negedge clk);
      chk({tag, " done single pulse"}, int'(cur_done), 0);
      chk({tag, " match held"}, int'(cur_match), exp_m);
      chk({tag, " addr back to 0"}, int'(cur_ad), 0);
   endtask

   typedef struct {
      logic [15:0] tpl;
      logic [15:0] img;
      int          em;
      int          ei;
   } svec_t;

   // Big template: address i is stroke (0) when i%4==0, giving 640 stroke pixels.
   // Image kinds: 0 same, 1 inverse, 2 all stroke, 3 all background, 4 stroke on even addresses.
   typedef struct {
      int ik;
      int em;
      int ei;
   } bvec_t;

   svec_t sv [4];
   bvec_t bv [5];

   task automatic load_big(input int ik);
      for (int i = 0; i < 4096; i++) begin
         tpl_b[i] = (i % 4 != 0);
         case (ik)
            0:       img_b[i] = tpl_b[i];
            1:       img_b[i] = !tpl_b[i];
            2:       img_b[i] = 1'b0;
            3:       img_b[i] = 1'b1;
            default: img_b[i] = (i % 2 != 0);
         endcase
      end
   endtask

   task automatic load_small(input logic [15:0] t, input logic [15:0] m);
      for (int i = 0; i < 16; i++) begin
         tpl_s[i] = t[i];
         img_s[i] = m[i];
      end
   endtask

   initial begin
      int dones, lat;

      sv[0] = '{16'hFF00, 16'hF0F0, 8, 4};
      sv[1] = '{16'h0000, 16'h0000, 16, 16};
      sv[2] = '{16'hFFFF, 16'h0000, 0, 0};
      sv[3] = '{16'h1234, 16'h1234, 16, 11};

      bv[0] = '{0, 2560, 640};
      bv[1] = '{1, 0, 0};
      bv[2] = '{2, 640, 640};
      bv[3] = '{3, 1920, 0};
      bv[4] = '{4, 1920, 640};

      rst_b = 1'b0; rst_s = 1'b0; start_b = 1'b0; start_s = 1'b0; sel_s = 1'b0;
      #1;
      chk("reset busy_b", int'(busy_b), 0);
      chk("reset done_b", int'(done_b), 0);
      chk("reset rom_ce_b", int'(mb.rom_ce), 0);
      chk("reset img_re_b", int'(mb.img_re), 0);
      chk("reset rom_ad_b", int'(mb.rom_ad), 0);
      chk("reset match_b", int'(match_b), 0);
      chk("reset ink_b", int'(ink_b), 0);
      chk("reset busy_s", int'(busy_s), 0);
      chk("reset match_s", int'(match_s), 0);
      repeat (2) @(negedge clk);
      rst_b = 1'b1; rst_s = 1'b1;

      sel_s = 1'b1;
      for (int v = 0; v < 4; v++) begin
         load_small(sv[v].tpl, sv[v].img);
         run_scan(16, $sformatf("small%0d", v), sv[v].em, sv[v].ei);
      end

      sel_s = 1'b0;
      for (int v = 0; v < 5; v++) begin
         load_big(bv[v].ik);
         run_scan(2560, $sformatf("big%0d", v), bv[v].em, bv[v].ei);
      end

      // start re-pulsed mid-scan and in the DONE cycle, then accepted in the cycle after DONE
      sel_s = 1'b1;
      load_small(16'hFF00, 16'hF0F0);
      dones = 0;
      for (int cyc = 0; cyc <= 20; cyc++) begin
         @(negedge clk);
         start_s = (cyc == 0 || cyc == 5 || cyc == 18 || cyc == 19);
         if (cyc >= 1 && cyc <= 19 && done_s) dones++;
         if (cyc == 18) begin
            chk("repulse done at 18", int'(done_s), 1);
            chk("repulse match", int'(match_s), 8);
            chk("repulse ink", int'(ink_s), 4);
         end
         if (cyc == 19) chk("repulse idle after done", int'(busy_s), 0);
         if (cyc == 20) begin
            chk("restart match cleared", int'(match_s), 0);
            chk("restart ink cleared", int'(ink_s), 0);
            chk("restart busy", int'(busy_s), 1);
         end
      end
      start_s = 1'b0;
      chk("repulse done count", dones, 1);
      lat = -1;
      for (int cyc = 21; cyc <= 60; cyc++) begin
         @(negedge clk);
         if (done_s) begin
            lat = cyc;
            break;
         end
      end
      chk("restart done cycle", lat, 37);
      chk("restart match", int'(match_s), 8);
      chk("restart ink", int'(ink_s), 4);
      @(negedge clk);

      // reset asserted in cycle 100 of a full-size scan
      sel_s = 1'b0;
      load_big(0);
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      repeat (99) @(negedge clk);
      chk("pre-reset busy", int'(busy_b), 1);
      rst_b = 1'b0;
      #1;
      chk("midrst busy", int'(busy_b), 0);
      chk("midrst done", int'(done_b), 0);
      chk("midrst rom_ce", int'(mb.rom_ce), 0);
      chk("midrst rom_oce", int'(mb.rom_oce), 0);
      chk("midrst img_re", int'(mb.img_re), 0);
      chk("midrst rom_ad", int'(mb.rom_ad), 0);
      chk("midrst img_ad", int'(mb.img_ad), 0);
      chk("midrst match", int'(match_b), 0);
      chk("midrst ink", int'(ink_b), 0);
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      dones = 0;
      repeat (2700) begin
         @(negedge clk);
         if (done_b || busy_b) dones++;
      end
      chk("no activity after reset", dones, 0);
      run_scan(2560, "post-reset", 2560, 640);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/template_scorer.md
# template_scorer

Sequential template-match scorer sitting directly downstream of the per-digit binary template ROMs (1-bit wide, 12-bit address, one-cycle read). On `start` it walks the template address space once, reads the template bit and the matching bit of the captured binarized image buffer in lock-step, and counts pixel agreements and stroke overlaps. The resulting score pair feeds the digit-decision stage that compares the ten templates.

## Interface

Parameters:
- `PIXELS`, 2560: number of template bits scanned, at addresses 0..PIXELS-1; must be in 1..4096.
- `ADDR_W`, 12: ROM and image address width.
- `SCORE_W`, 12: counter width; must hold `PIXELS`.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request one scan; sampled only in IDLE.
- `busy`  out  1  high from the first address cycle through the last data cycle.
- `done`  out  1  one-cycle pulse; scores are valid in that cycle.
- `match_cnt`  out  SCORE_W  count of pixels where template bit equals image bit.
- `ink_cnt`  out  SCORE_W  count of pixels where both bits are 0 (stroke pixel in both).
- `rom_ce`  out  1  template ROM clock enable.
- `rom_oce`  out  1  template ROM output enable; driven equal to `rom_ce`.
- `rom_ad`  out  ADDR_W  template ROM address.
- `rom_dout`  in  1  template bit, valid the cycle after its address is presented.
- `img_re`  out  1  image buffer read enable; equal to `rom_ce`.
- `img_ad`  out  ADDR_W  image buffer address; always equal to `rom_ad`.
- `img_dout`  in  1  image bit, with the same one-cycle latency as `rom_dout`.

## Operation

- Pixel convention for both sources: 1 = background, 0 = stroke.
- FSM states:
  - IDLE: on `start`, go to RUN and clear both counters and the address counter.
  - RUN: assert `rom_ce`/`img_re` and present address `a`. Increment `a` each cycle. After address `PIXELS-1` is presented, go to DRAIN.
  - DRAIN: one cycle; enables are low and the last data beat is accumulated. Then go to DONE.
  - DONE: `done`=1 for one cycle, then return to IDLE.
- A `valid_d` flag is `rom_ce` delayed by one cycle. While `valid_d`=1:
  - `match_cnt` increments when `rom_dout == img_dout`.
  - `ink_cnt` increments when both bits are 0.
- Counters are saturation-free; the width rule guarantees no overflow.
- `match_cnt`/`ink_cnt` hold their final values from DONE until the next accepted `start`, which clears them.
- `start` outside IDLE is ignored, including in DONE. `start` held high re-triggers on the IDLE cycle that follows DONE.
- `rom_ad`/`img_ad` hold their last value when the enables are low. The address is 0 in IDLE.
- Reset: asynchronous. All outputs go to 0 immediately and the FSM goes to IDLE. A reset mid-scan aborts the scan with no `done` and leaves counters at 0.
- `PIXELS`=1: RUN lasts exactly one cycle.

## Timing

- Cycle numbering: cycle 0 is the cycle in which `start`=1 in IDLE.
- Cycles 1..PIXELS: RUN. Address `k` is presented in cycle `k+1`.
- Cycle PIXELS+1: DRAIN; the last data beat arrives.
- Cycle PIXELS+2: `done`=1 and the counts are final. Total latency is PIXELS+2 cycles; this is 2562 at the defaults.
- `busy` is high in cycles 1..PIXELS+1 and low in the `done` cycle.
- Back-to-back throughput: the earliest next accepted `start` is cycle PIXELS+3.
- Reset values: `busy`, `done`, `rom_ce`, `rom_oce`, `img_re` = 0; `rom_ad`, `img_ad`, `match_cnt`, `ink_cnt` = 0.

## Structure

- Shared package `digit_pkg` holds:
  - constants `IMG_PIXELS`=2560, `PIX_ADDR_W`=12, `SCORE_W`=12;
  - the FSM state enum (IDLE, RUN, DRAIN, DONE), which the decision stage also uses for status.
- One sub-module, `score_accum`: the two counters, the clear input and the `valid_d`-gated increment logic.
- The FSM and address counter stay in `template_scorer`.

## Test plan

- Image model equals the template ROM image (2560 bits), `start` pulsed: `done` in cycle 2562, `match_cnt`=2560, `ink_cnt` = number of template zeros.
- Image is the bitwise inverse of the template: `match_cnt`=0, `ink_cnt`=0.
- `PIXELS`=16, template 16'hFF00, image 16'hF0F0: `match_cnt`=8, `ink_cnt`=4, `done` in cycle 18.
- `start` re-pulsed in cycles 5 and PIXELS+2 of a scan: ignored, single `done`, counts unchanged. A pulse in cycle PIXELS+3 starts a new scan, and the counters read 0 in cycle PIXELS+4.
- `rst_n` asserted in cycle 100 of a scan: all outputs 0 in the same cycle, no `done` ever. A fresh `start` after release gives the correct full result.
- Address trace check: `rom_ad` = `img_ad` = 0..PIXELS-1, consecutive, with enables high exactly PIXELS cycles.
